alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer_pkg.sv | 30 +++
 rtl/alu_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared ALU opcode encoding plus the sequencer's macro-op and state types.
package alu_sequencer_pkg;

  localparam int W   = 8;
  localparam int OPS = 4;
  localparam int CW  = $clog2(W);

  typedef enum logic [OPS-1:0] {
    NOP = 4'h0,
    ADD = 4'h1,
    SUB = 4'h2,
    SLT = 4'h3,
    AND = 4'h4,
    OR  = 4'h5,
    XOR = 4'h6
  } op_mne;

  typedef enum logic {
    MUL  = 1'b0,
    DIVU = 1'b1
  } macop_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_A = 2'd1,
    STEP_B = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Unsigned MUL/DIVU as a sequence of single-cycle ALU ops; result in 2W+1 cycles.
// ALU_SEQ_DIV_EN adds the restoring divider; without it DIVU returns zeros at once.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic           i_mac_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic [W-1:0]   i_alu_out,
  output logic [OPS-1:0] o_alu_op,
  output logic [W-1:0]   o_alu_a,
  output logic [W-1:0]   o_alu_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [W-1:0]   o_hi,
  output logic [W-1:0]   o_lo,
  output logic           o_div_zero
);

  seq_state_t      r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [W-1:0]    r_b, w_b_nxt;
  logic [W-1:0]    r_hi, w_hi_nxt;
  logic [W-1:0]    r_lo, w_lo_nxt;
  logic [W-1:0]    r_sum, w_sum_nxt;
  logic            r_dz, w_dz_nxt;
  op_mne           w_alu_op;
  logic [W-1:0]    w_alu_a, w_alu_b, w_addend;
  logic            w_last;
`ifdef ALU_SEQ_DIV_EN
  macop_t          r_op, w_op_nxt;
  logic            r_lt, w_lt_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic [W:0]      w_shift;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sum   <= '0;
      r_dz    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      r_op    <= MUL;
      r_lt    <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_b     <= w_b_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_sum   <= w_sum_nxt;
      r_dz    <= w_dz_nxt;
`ifdef ALU_SEQ_DIV_EN
      r_op    <= w_op_nxt;
      r_lt    <= w_lt_nxt;
      r_ovf   <= w_ovf_nxt;
`endif
    end
  end

  // Accumulators double as the result outputs: they only move after an accepted Start.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_b_nxt     = r_b;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_sum_nxt   = r_sum;
    w_dz_nxt    = r_dz;
    w_alu_op    = NOP;
    w_alu_a     = '0;
    w_alu_b     = '0;
    w_addend    = r_lo[0] ? r_b : '0;
    w_last      = (r_cnt == CW'(W-1));
`ifdef ALU_SEQ_DIV_EN
    w_op_nxt    = r_op;
    w_lt_nxt    = r_lt;
    w_ovf_nxt   = r_ovf;
    w_shift     = {r_hi, r_lo[W-1]};
`endif
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_cnt_nxt   = '0;
          w_sum_nxt   = '0;
          w_dz_nxt    = 1'b0;
          w_b_nxt     = i_b;
          w_hi_nxt    = '0;
          w_lo_nxt    = i_a;
          w_state_nxt = STEP_A;
`ifdef ALU_SEQ_DIV_EN
          w_op_nxt    = macop_t'(i_mac_op);
          if (i_mac_op && (i_b == '0)) begin
            w_hi_nxt    = i_a;
            w_lo_nxt    = '1;
            w_dz_nxt    = 1'b1;
            w_state_nxt = DONE;
          end
`else
          if (i_mac_op) begin
            w_lo_nxt    = '0;
            w_state_nxt = DONE;
          end
`endif
        end
      end
      STEP_A: begin
`ifdef ALU_SEQ_DIV_EN
        if (r_op == DIVU) begin
          w_hi_nxt  = w_shift[W-1:0];
          w_ovf_nxt = w_shift[W];
          w_lo_nxt  = {r_lo[W-2:0], 1'b0};
          w_alu_op  = SLT;
          w_alu_a   = w_shift[W-1:0];
          w_alu_b   = r_b;
          w_lt_nxt  = i_alu_out[0];
        end else
`endif
        begin
          w_alu_op  = ADD;
          w_alu_a   = r_hi;
          w_alu_b   = w_addend;
          w_sum_nxt = i_alu_out;
        end
        w_state_nxt = STEP_B;
      end
      STEP_B: begin
`ifdef ALU_SEQ_DIV_EN
        // A shifted-out bit means rem >= 2^W > B, so the subtract must happen and wraps correctly.
        if (r_op == DIVU) begin
          if (r_ovf || !r_lt) begin
            w_alu_op = SUB;
            w_alu_a  = r_hi;
            w_alu_b  = r_b;
            w_hi_nxt = i_alu_out;
            w_lo_nxt = {r_lo[W-1:1], 1'b1};
          end
        end else
`endif
        begin
          // sum < addend exactly when the W-bit add wrapped.
          w_alu_op             = SLT;
          w_alu_a              = r_sum;
          w_alu_b              = w_addend;
          {w_hi_nxt, w_lo_nxt} = {i_alu_out[0], r_sum, r_lo[W-1:1]};
        end
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = STEP_A;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_alu_op   = w_alu_op;
  assign o_alu_a    = w_alu_a;
  assign o_alu_b    = w_alu_b;
  assign o_busy     = (r_state != IDLE);
  assign o_done     = (r_state == DONE);
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_div_zero = r_dz;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural combinational ALU alongside.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, mac_op;
  logic [7:0] a, b, alu_out;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, hi, lo;
  logic       busy, done, dz;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_mac_op(mac_op),
    .i_a(a), .i_b(b), .i_alu_out(alu_out),
    .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo), .o_div_zero(dz)
  );

  always_comb begin
    case (alu_op)
      4'h1:    alu_out = alu_a + alu_b;
      4'h2:    alu_out = alu_a - alu_b;
      4'h3:    alu_out = {7'd0, (alu_a < alu_b)};
      default: alu_out = 8'd0;
    endcase
  end

  typedef struct {
    logic       op;
    logic [7:0] a, b, hi, lo;
    logic       dz;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] hi, lo;
    logic       dz;
    int         lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic exp_t expect_for(input vec_t v);
    exp_t e;
    e.hi = v.hi; e.lo = v.lo; e.dz = v.dz; e.lat = v.lat;
`ifndef ALU_SEQ_DIV_EN
    if (v.op) begin
      e.hi = 8'h00; e.lo = 8'h00; e.dz = 1'b0; e.lat = 1;
    end
`endif
    return e;
  endfunction

  // Drives Start for one cycle; returns #1 into cycle 1.
  task automatic issue(input vec_t v);
    @(negedge clk);
    mac_op = v.op; a = v.a; b = v.b; start = 1'b1;
    sb.push_back(expect_for(v));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int cyc0, output exp_t e);
    int cyc = cyc0;
    chk({tag, " busy"}, busy, 1);
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 0, 1);
      e = '{8'h00, 8'h00, 1'b0, 0};
    end else begin
      e = sb.pop_front();
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " latency"}, cyc, e.lat);
    chk({tag, " hi"}, hi, e.hi);
    chk({tag, " lo"}, lo, e.lo);
    chk({tag, " divzero"}, dz, e.dz);
    chk({tag, " alu idle in DONE"}, {alu_op, alu_a, alu_b}, 0);
  endtask

  task automatic no_done(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk({tag, " spurious done"}, seen, 0);
  endtask

  initial begin
    exp_t e;
    vec_t v;
    rst = 1'b1; start = 1'b0; mac_op = 1'b0; a = 8'd0; b = 8'd0;

    vecs.push_back('{1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 17});
    vecs.push_back('{1'b0, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 17});
    vecs.push_back('{1'b0, 8'd0,   8'd200, 8'h00, 8'h00, 1'b0, 17});
    vecs.push_back('{1'b0, 8'd1,   8'd255, 8'h00, 8'hFF, 1'b0, 17});
    vecs.push_back('{1'b0, 8'd128, 8'd2,   8'h01, 8'h00, 1'b0, 17});
    vecs.push_back('{1'b0, 8'd200, 8'd100, 8'h4E, 8'h20, 1'b0, 17});
    vecs.push_back('{1'b1, 8'd200, 8'd7,   8'h04, 8'h1C, 1'b0, 17});
    vecs.push_back('{1'b1, 8'd255, 8'd129, 8'h7E, 8'h01, 1'b0, 17});
    vecs.push_back('{1'b1, 8'd200, 8'd0,   8'hC8, 8'hFF, 1'b1, 1});
    vecs.push_back('{1'b1, 8'd7,   8'd200, 8'h07, 8'h00, 1'b0, 17});
    vecs.push_back('{1'b1, 8'd255, 8'd1,   8'h00, 8'hFF, 1'b0, 17});

    repeat (3) @(posedge clk);
    #1;
    chk("reset hi/lo", {hi, lo}, 0);
    chk("reset flags", {busy, done, dz}, 0);
    chk("reset alu", {alu_op, alu_a, alu_b}, 0);
    rst = 1'b0;

    // Back-to-back: each new Start lands on the first IDLE cycle after DONE.
    foreach (vecs[i]) begin
      issue(vecs[i]);
      wait_done($sformatf("vec%0d", i), 1, e);
      @(posedge clk); #1;
      chk($sformatf("vec%0d idle busy", i), {busy, done}, 0);
      chk($sformatf("vec%0d hold", i), {hi, lo, dz}, {e.hi, e.lo, e.dz});
    end

    // Start at cycle 5 of a MUL must be ignored.
    issue('{1'b0, 8'd13, 8'd11, 8'h00, 8'h8F, 1'b0, 17});
    repeat (4) begin @(posedge clk); #1; end
    mac_op = 1'b0; a = 8'd9; b = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy start", 6, e);
    no_done("busy start", 20);

    // Start during the DONE cycle must be ignored.
    issue('{1'b0, 8'd3, 8'd5, 8'h00, 8'h0F, 1'b0, 17});
    wait_done("done start", 1, e);
    mac_op = 1'b0; a = 8'd200; b = 8'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done start busy", busy, 0);
    no_done("done start", 20);
    chk("done start hold", {hi, lo}, 16'h000F);

    // Reset at cycle 8 aborts with no Done.
    issue('{1'b0, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 17});
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort hi/lo", {hi, lo}, 0);
    chk("abort flags", {busy, done, dz}, 0);
    chk("abort alu", {alu_op, alu_a, alu_b}, 0);
    sb.delete();
    no_done("abort", 25);

    v = '{1'b0, 8'd13, 8'd11, 8'h00, 8'h8F, 1'b0, 17};
    issue(v);
    wait_done("after abort", 1, e);
    v = '{1'b1, 8'd200, 8'd7, 8'h04, 8'h1C, 1'b0, 17};
    @(posedge clk); #1;
    issue(v);
    wait_done("after abort div", 1, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
